unary_stream_gen: RTL and testbench

Upstream source for the unary adder stage. It accepts a pair of binary operands through a valid/ready handshake and serialises each operand into a thermometer-coded bit stream of fixed length LEN on A/B, with en asserted. It then sequences the adder into its output phase by holding read_or_write high for WR_CYC cycles. A one-cycle done pulse ends the transaction.

---
 rtl/unary_pkg.sv | 19 +
 rtl/unary_lane_ser.sv | 47 ++++
 rtl/unary_stream_gen.sv | 171 +++++++++++++++++
 tb/tb_unary_stream_gen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/unary_pkg.sv
// Shared types and defaults for the unary stream generator.
package unary_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WRITE  = 2'd2
    } state_e;

    localparam int unsigned UNARY_LEN    = 19;
    localparam int unsigned UNARY_WIDTH  = 5;
    localparam int unsigned UNARY_WR_CYC = 10;

    // Clamp a binary operand to the largest value a LEN-cycle stream can carry.
    function automatic int unsigned sat_to_len(input int unsigned value, input int unsigned len);
        return (value > len) ? len : value;
    endfunction

endpackage

// File: rtl/unary_lane_ser.sv
// One operand lane: holds the clamped operand and emits its thermometer bit
// for a given stream index (ones first, then zeros).
module unary_lane_ser
    import unary_pkg::*;
#(
    parameter int unsigned WIDTH = UNARY_WIDTH,
    parameter int unsigned LEN   = UNARY_LEN,
    parameter int unsigned CW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic [CW-1:0]    idx_i,
    output logic             bit_o,
    output logic             over_o
);

    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] val_d;
    logic [WIDTH-1:0] clamp;

    assign clamp  = WIDTH'(sat_to_len(32'(din_i), LEN));
    assign over_o = (32'(din_i) > LEN);

    // On the accept edge the register still holds the old operand, so bit 0
    // is taken from the freshly clamped input instead.
    assign bit_o = (32'(idx_i) < 32'(load_i ? clamp : val_q));

    always_comb begin
        val_d = val_q;
        if (load_i) begin
            val_d = clamp;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

endmodule

// File: rtl/unary_stream_gen.sv
// Serialises a binary operand pair into LEN-cycle thermometer streams, then
// holds read_or_write for WR_CYC cycles. Optional abort input: UNARY_GEN_ABORT_EN.
module unary_stream_gen
    import unary_pkg::*;
#(
    parameter int unsigned WIDTH  = UNARY_WIDTH,
    parameter int unsigned LEN    = UNARY_LEN,
    parameter int unsigned WR_CYC = UNARY_WR_CYC
) (
    input  logic             clk,
    input  logic             rst,
`ifdef UNARY_GEN_ABORT_EN
    input  logic             abort,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             A,
    output logic             B,
    output logic             en,
    output logic             read_or_write,
    output logic             sat,
    output logic             done
);

    localparam int unsigned CW = $clog2(LEN + WR_CYC + 1);
    localparam logic [CW-1:0] LAST_STREAM = CW'(LEN - 1);
    localparam logic [CW-1:0] LAST_WRITE  = CW'(LEN + WR_CYC - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          a_q, a_d;
    logic          b_q, b_d;
    logic          en_q, en_d;
    logic          rw_q, rw_d;
    logic          sat_q, sat_d;
    logic          done_q, done_d;

    logic          accept;
    logic          show_bits;
    logic [CW-1:0] idx;
    logic          abort_w;
    logic          bit_a, bit_b;
    logic          over_a, over_b;

`ifdef UNARY_GEN_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    unary_lane_ser #(.WIDTH(WIDTH), .LEN(LEN), .CW(CW)) u_lane_a (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .din_i  (in_a),
        .idx_i  (idx),
        .bit_o  (bit_a),
        .over_o (over_a)
    );

    unary_lane_ser #(.WIDTH(WIDTH), .LEN(LEN), .CW(CW)) u_lane_b (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .din_i  (in_b),
        .idx_i  (idx),
        .bit_o  (bit_b),
        .over_o (over_b)
    );

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        en_d      = en_q;
        rw_d      = rw_q;
        sat_d     = sat_q;
        done_d    = 1'b0;
        accept    = 1'b0;
        show_bits = 1'b0;
        idx       = '0;

        unique case (state_q)
            ST_IDLE: begin
                en_d = 1'b0;
                rw_d = 1'b0;
                if (in_valid) begin
                    accept    = 1'b1;
                    show_bits = 1'b1;
                    state_d   = ST_STREAM;
                    cnt_d     = '0;
                    en_d      = 1'b1;
                    sat_d     = over_a | over_b;
                end
            end
            ST_STREAM: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STREAM) begin
                    state_d = ST_WRITE;
                    rw_d    = 1'b1;
                end else begin
                    show_bits = 1'b1;
                    idx       = cnt_q + CW'(1);
                end
            end
            ST_WRITE: begin
                if (cnt_q == LAST_WRITE) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    en_d    = 1'b0;
                    rw_d    = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                en_d    = 1'b0;
                rw_d    = 1'b0;
            end
        endcase

        // Abort drops the sequence silently; sat keeps the last acceptance result.
        if (abort_w && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            en_d      = 1'b0;
            rw_d      = 1'b0;
            done_d    = 1'b0;
            show_bits = 1'b0;
        end

        a_d = show_bits & bit_a;
        b_d = show_bits & bit_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            en_q    <= 1'b0;
            rw_q    <= 1'b0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            en_q    <= en_d;
            rw_q    <= rw_d;
            sat_q   <= sat_d;
            done_q  <= done_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE) & ~rst;
    assign A             = a_q;
    assign B             = b_q;
    assign en            = en_q;
    assign read_or_write = rw_q;
    assign sat           = sat_q;
    assign done          = done_q;

endmodule

// File: tb/tb_unary_stream_gen.sv
// Self-checking bench for unary_stream_gen; expected waveforms come from a
// per-cycle arithmetic model of the transaction timeline.
module tb_unary_stream_gen;

    localparam int unsigned WIDTH  = 5;
    localparam int unsigned LEN    = 19;
    localparam int unsigned WR_CYC = 10;
    localparam int          TOT    = LEN + WR_CYC;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             A;
    logic             B;
    logic             en;
    logic             read_or_write;
    logic             sat;
    logic             done;
`ifdef UNARY_GEN_ABORT_EN
    logic             abort;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic exp_sat = 1'b0;

    always #5 clk = ~clk;

    unary_stream_gen #(.WIDTH(WIDTH), .LEN(LEN), .WR_CYC(WR_CYC)) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef UNARY_GEN_ABORT_EN
        .abort         (abort),
`endif
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .A             (A),
        .B             (B),
        .en            (en),
        .read_or_write (read_or_write),
        .sat           (sat),
        .done          (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Idle-cycle expectations: no stream, no pulse, ready, sat held.
    task automatic check_idle(input string tag, input logic exp_ready);
        check({tag, " A"}, 32'(A), 0);
        check({tag, " B"}, 32'(B), 0);
        check({tag, " en"}, 32'(en), 0);
        check({tag, " rw"}, 32'(read_or_write), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " ready"}, 32'(in_ready), 32'(exp_ready));
        check({tag, " sat"}, 32'(sat), 32'(exp_sat));
    endtask

    // Presents (a,b) at the current negedge and checks every cycle after the
    // accept edge. Returns at the done cycle, or early after checking cycle stop_at.
    task automatic run_txn(input int a, input int b, input bit noisy, input int stop_at);
        int ca;
        int cb;
        ca = (a > int'(LEN)) ? int'(LEN) : a;
        cb = (b > int'(LEN)) ? int'(LEN) : b;
        check("ready before accept", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_a     = WIDTH'(a);
        in_b     = WIDTH'(b);
        exp_sat  = (a > int'(LEN)) || (b > int'(LEN));
        for (int k = 0; k <= TOT; k++) begin
            @(negedge clk);
            check($sformatf("A(%0d,%0d) k=%0d", a, b, k), 32'(A), 32'(k < ca));
            check($sformatf("B(%0d,%0d) k=%0d", a, b, k), 32'(B), 32'(k < cb));
            check($sformatf("en k=%0d", k), 32'(en), 32'(k < TOT));
            check($sformatf("rw k=%0d", k), 32'(read_or_write), 32'(k >= int'(LEN) && k < TOT));
            check($sformatf("done k=%0d", k), 32'(done), 32'(k == TOT));
            check($sformatf("ready k=%0d", k), 32'(in_ready), 32'(k == TOT));
            check($sformatf("sat k=%0d", k), 32'(sat), 32'(exp_sat));
            if (k == stop_at) return;
            in_valid = (noisy && k < TOT) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_a     = WIDTH'($urandom);
            in_b     = WIDTH'($urandom);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
`ifdef UNARY_GEN_ABORT_EN
        abort    = 1'b0;
`endif
        @(negedge clk);
        check_idle("in reset", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle("after reset", 1'b1);
        end

        // Directed operand pairs, including the clamp boundaries.
        run_txn(3, 5, 1'b0, -1);
        in_valid = 1'b0;
        @(negedge clk);
        check_idle("idle after 3/5", 1'b1);
        run_txn(19, 0, 1'b0, -1);
        run_txn(25, 31, 1'b0, -1);
        in_valid = 1'b0;
        @(negedge clk);
        check_idle("idle after clamp", 1'b1);

        // Back-to-back with in_valid toggling during each transaction.
        run_txn(2, 7, 1'b1, -1);
        run_txn(7, 2, 1'b1, -1);
        run_txn(20, 19, 1'b1, -1);
        in_valid = 1'b0;
        @(negedge clk);
        check_idle("idle after b2b", 1'b1);

        // Synchronous reset at STREAM cycle 8.
        run_txn(10, 12, 1'b0, 8);
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_sat  = 1'b0;
        @(negedge clk);
        check_idle("reset mid-stream", 1'b0);
        rst = 1'b0;
        repeat (TOT) begin
            @(negedge clk);
            check_idle("after mid reset", 1'b1);
        end
        run_txn(4, 1, 1'b0, -1);
        in_valid = 1'b0;
        @(negedge clk);
        check_idle("idle after recovery", 1'b1);

`ifdef UNARY_GEN_ABORT_EN
        // Abort in WRITE cycle 3: sequence drops, sat stays, no done.
        run_txn(6, 30, 1'b0, int'(LEN) + 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("abort in write", 1'b1);
        repeat (TOT) begin
            @(negedge clk);
            check_idle("after abort", 1'b1);
        end
        // Abort is ignored in IDLE; the pair is still accepted.
        abort = 1'b1;
        run_txn(9, 3, 1'b0, 0);
        abort = 1'b0;
        in_valid = 1'b0;
        for (int k = 1; k <= TOT; k++) begin
            @(negedge clk);
            check($sformatf("post-idle-abort A k=%0d", k), 32'(A), 32'(k < 9));
            check($sformatf("post-idle-abort done k=%0d", k), 32'(done), 32'(k == TOT));
        end
`endif

        // Randomized operand pairs, some back-to-back.
        for (int t = 0; t < 10; t++) begin
            run_txn(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'b1, -1);
            if ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                @(negedge clk);
                check_idle($sformatf("random idle %0d", t), 1'b1);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_idle("final idle", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
